// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the ibus/dbus memory-port arbiter: bus payloads, access size,
// FSM state and transaction owner encodings.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t RESP  = 2'd2;

  typedef logic [1:0] arb_owner_t;
  localparam arb_owner_t OWNER_NONE = 2'd0;
  localparam arb_owner_t OWNER_I    = 2'd1;
  localparam arb_owner_t OWNER_D    = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] data;
  } cbus_resp_t;

  // Instruction fetches are always full-word reads.
  function automatic cbus_req_t ibusToCbus(ibus_req_t r);
    cbus_req_t c;
    c.valid    = 1'b1;
    c.is_write = 1'b0;
    c.size     = MSIZE4;
    c.addr     = r.addr;
    c.strobe   = 8'h00;
    c.data     = 64'h0;
    return c;
  endfunction

  function automatic cbus_req_t dbusToCbus(dbus_req_t r);
    cbus_req_t c;
    c.valid    = 1'b1;
    c.is_write = |r.strobe;
    c.size     = r.size;
    c.addr     = r.addr;
    c.strobe   = r.strobe;
    c.data     = r.data;
    return c;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_select.sv
// Arbitration policy: data priority with a starvation guard on fetch, or plain
// alternation when ARB_ROUND_ROBIN_EN is defined.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter_arb_select #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic iValid_i,
  input  logic dValid_i,
  input  logic grantEn_i,
  output logic grantD_o,
  output logic grantI_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic preferI_q;
  logic preferI_d;

  always_comb begin
    grantD_o = 1'b0;
    grantI_o = 1'b0;
    if (iValid_i && dValid_i) begin
      grantI_o = preferI_q;
      grantD_o = !preferI_q;
    end else begin
      grantI_o = iValid_i;
      grantD_o = dValid_i;
    end
  end

  // Whoever wins now loses the next contested arbitration.
  always_comb begin
    preferI_d = preferI_q;
    if (grantEn_i) begin
      preferI_d = grantD_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preferI_q <= 1'b0;
    end else begin
      preferI_q <= preferI_d;
    end
  end
`else
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  always_comb begin
    grantD_o = 1'b0;
    grantI_o = 1'b0;
    if (iValid_i && dValid_i) begin
      grantD_o = (streak_q < STREAK_MAX);
      grantI_o = !(streak_q < STREAK_MAX);
    end else begin
      grantI_o = iValid_i;
      grantD_o = dValid_i;
    end
  end

  // Count data wins only while fetch is actually waiting; saturate at the cap.
  always_comb begin
    streak_d = streak_q;
    if (grantEn_i) begin
      if (grantD_o && iValid_i) begin
        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-beat memory port between the fetch (ibus) and memory-stage
// (dbus) requesters via a grant / issue / respond sequence.
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp,
  output logic       busy
);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  cbus_req_t   creq_q, creq_d;
  logic [63:0] rdata_q, rdata_d;

  logic grantEn;
  logic grantD;
  logic grantI;

  assign grantEn = (state_q == IDLE) && (ireq.valid || dreq.valid);

  mem_bus_arbiter_arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK),
    .STREAK_W       (STREAK_W)
  ) u_select (
    .clk      (clk),
    .rst      (rst),
    .iValid_i (ireq.valid),
    .dValid_i (dreq.valid),
    .grantEn_i(grantEn),
    .grantD_o (grantD),
    .grantI_o (grantI)
  );

  // The winner's payload is captured once in IDLE so requester changes later on
  // cannot disturb the downstream access.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    creq_d  = creq_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grantEn && grantD) begin
          creq_d  = dbusToCbus(dreq);
          owner_d = OWNER_D;
          state_d = ISSUE;
        end else if (grantEn && grantI) begin
          creq_d  = ibusToCbus(ireq);
          owner_d = OWNER_I;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cresp.ready) begin
          rdata_d = cresp.data;
          state_d = RESP;
        end
      end
      RESP: begin
        owner_d = OWNER_NONE;
        state_d = IDLE;
      end
      default: begin
        owner_d = OWNER_NONE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_NONE;
      creq_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      creq_q  <= creq_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  always_comb begin
    creq  = '0;
    iresp = '0;
    dresp = '0;
    if (state_q == ISSUE) begin
      creq       = creq_q;
      creq.valid = 1'b1;
    end
    if (state_q == RESP) begin
      if (owner_q == OWNER_I && ireq.valid) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = rdata_q;
      end
      if (owner_q == OWNER_D && dreq.valid) begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = rdata_q;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table of single transactions
// plus hand sequences for streak limit, mid-transaction drop and reset.
import mem_bus_arbiter_pkg::*;

module tb_mem_bus_arbiter;

  logic       clk;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       busy;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        iValid;
    logic [31:0] iAddr;
    logic        dValid;
    logic [31:0] dAddr;
    msize_t      dSize;
    logic [7:0]  dStrobe;
    logic [63:0] dData;
    int          lat;
    logic [63:0] memData;
    logic        expD;
    logic        expWrite;
    logic [31:0] expAddr;
    msize_t      expSize;
    logic [7:0]  expStrobe;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs[5];

  mem_bus_arbiter #(
    .MAX_DATA_STREAK(4),
    .STREAK_W       (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .ireq (ireq),
    .iresp(iresp),
    .dreq (dreq),
    .dresp(dresp),
    .creq (creq),
    .cresp(cresp),
    .busy (busy)
  );

  // Free-running clock, rising edge is the active edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and log a failure line.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive both requester ports from a vector.
  task automatic applyStimulus(input vec_t v);
    ireq.valid  = v.iValid;
    ireq.addr   = v.iAddr;
    dreq.valid  = v.dValid;
    dreq.addr   = v.dAddr;
    dreq.size   = v.dSize;
    dreq.strobe = v.dStrobe;
    dreq.data   = v.dData;
  endtask

  // Run one transaction from IDLE: check the issued request, hold it for v.lat
  // ISSUE cycles while scrambling requester payloads, then check the response.
  task automatic runTxn(input vec_t v, input bit dropOwner, input string tag);
    cbus_req_t  first;
    ibus_req_t  savedI;
    dbus_req_t  savedD;
    bit         stable;
    savedI = ireq;
    savedD = dreq;
    stable = 1'b1;
    @(posedge clk); #1;
    first = creq;
    checkOutput({tag, " busy"}, 64'(busy), 64'd1);
    checkOutput({tag, " valid"}, 64'(creq.valid), 64'd1);
    checkOutput({tag, " owner"}, 64'(creq.is_write | (creq.strobe != 8'h00) | (creq.addr == v.dAddr && v.dValid)),
                64'(v.expD & (v.expWrite | 1'b1)));
    checkOutput({tag, " is_write"}, 64'(creq.is_write), 64'(v.expWrite));
    checkOutput({tag, " addr"}, 64'(creq.addr), 64'(v.expAddr));
    checkOutput({tag, " size"}, 64'(creq.size), 64'(v.expSize));
    checkOutput({tag, " strobe"}, 64'(creq.strobe), 64'(v.expStrobe));
    checkOutput({tag, " wdata"}, creq.data, v.expData);
    ireq.addr = ireq.addr ^ 32'h10;
    dreq.addr = dreq.addr ^ 32'h10;
    dreq.data = ~dreq.data;
    for (int c = 1; c <= v.lat; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (creq !== first) stable = 1'b0;
      if (c == v.lat) begin
        cresp.ready = 1'b1;
        cresp.data  = v.memData;
      end
    end
    @(posedge clk); #1;
    cresp = '0;
    ireq  = savedI;
    dreq  = savedD;
    checkOutput({tag, " payload stable"}, 64'(stable), 64'd1);
    checkOutput({tag, " valid off in resp"}, 64'(creq.valid), 64'd0);
    if (v.expD) begin
      checkOutput({tag, " dresp ok"}, 64'({dresp.addr_ok, dresp.data_ok}), 64'd3);
      checkOutput({tag, " dresp data"}, dresp.data, v.memData);
      checkOutput({tag, " iresp quiet"}, 64'(iresp == '0), 64'd1);
    end else begin
      checkOutput({tag, " iresp ok"}, 64'({iresp.addr_ok, iresp.data_ok}), 64'd3);
      checkOutput({tag, " iresp data"}, iresp.data, v.memData);
      checkOutput({tag, " dresp quiet"}, 64'(dresp == '0), 64'd1);
    end
    @(posedge clk); #1;
    checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " single pulse"}, 64'(iresp.data_ok | dresp.data_ok), 64'd0);
    if (dropOwner) begin
      if (v.expD) dreq.valid = 1'b0;
      else        ireq.valid = 1'b0;
    end
  endtask

  function automatic vec_t streakVec(input logic expD, input logic [63:0] memData);
    vec_t v;
    v.iValid    = 1'b1;
    v.iAddr     = 32'h8000_0100;
    v.dValid    = 1'b1;
    v.dAddr     = 32'h8000_3000;
    v.dSize     = MSIZE4;
    v.dStrobe   = 8'h0F;
    v.dData     = 64'h1234;
    v.lat       = 1;
    v.memData   = memData;
    v.expD      = expD;
    v.expWrite  = expD;
    v.expAddr   = expD ? 32'h8000_3000 : 32'h8000_0100;
    v.expSize   = MSIZE4;
    v.expStrobe = expD ? 8'h0F : 8'h00;
    v.expData   = expD ? 64'h1234 : 64'h0;
    return v;
  endfunction

  initial begin
    logic seqD[6];
    vec_t v;
    testsRun    = 0;
    testsFailed = 0;

    vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, MSIZE1, 8'h00, 64'h0,
                1, 64'h13,
                1'b0, 1'b0, 32'h8000_0000, MSIZE4, 8'h00, 64'h0};
    vecs[1] = '{1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF,
                1, 64'h0,
                1'b1, 1'b1, 32'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0, MSIZE1, 8'h00, 64'h0,
                2, 64'h0010_0093,
                1'b0, 1'b0, 32'h8000_0004, MSIZE4, 8'h00, 64'h0};
    vecs[3] = '{1'b0, 32'h0, 1'b1, 32'h8000_2000, MSIZE4, 8'h00, 64'h55,
                6, 64'hCAFE_F00D,
                1'b1, 1'b0, 32'h8000_2000, MSIZE4, 8'h00, 64'h55};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h8000_2008, MSIZE1, 8'h01, 64'hA5,
                2, 64'h0,
                1'b1, 1'b1, 32'h8000_2008, MSIZE1, 8'h01, 64'hA5};

    rst   = 1'b1;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    @(posedge clk); #1;
    checkOutput("reset creq", 64'(creq == '0), 64'd1);
    checkOutput("reset iresp", 64'(iresp == '0), 64'd1);
    checkOutput("reset dresp", 64'(dresp == '0), 64'd1);
    checkOutput("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;

    cresp.ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("stray ready busy", 64'(busy), 64'd0);
    checkOutput("stray ready creq", 64'(creq.valid), 64'd0);
    cresp = '0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      runTxn(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

`ifdef ARB_ROUND_ROBIN_EN
    seqD = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    seqD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    v = streakVec(1'b1, 64'h0);
    applyStimulus(v);
    for (int n = 0; n < 6; n++) begin
      v = streakVec(seqD[n], 64'(n + 100));
      runTxn(v, 1'b0, $sformatf("streak%0d", n));
    end
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;

    // Data requester abandons its read mid-flight: no response may appear.
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h8000_4000;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h00;
    @(posedge clk); #1;
    checkOutput("drop issue", 64'(creq.valid), 64'd1);
    dreq.valid  = 1'b0;
    cresp.ready = 1'b1;
    cresp.data  = 64'h99;
    @(posedge clk); #1;
    cresp = '0;
    checkOutput("drop resp busy", 64'(busy), 64'd1);
    checkOutput("drop dresp quiet", 64'(dresp == '0), 64'd1);
    checkOutput("drop iresp quiet", 64'(iresp == '0), 64'd1);
    @(posedge clk); #1;
    checkOutput("drop back idle", 64'(busy), 64'd0);

    // Reset in the middle of ISSUE, then a clean fetch afterwards.
    ireq.valid = 1'b1;
    ireq.addr  = 32'h8000_0200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre-reset issue", 64'(creq.valid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset creq valid", 64'(creq.valid), 64'd0);
    checkOutput("reset busy mid", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{1'b1, 32'h8000_0200, 1'b0, 32'h0, MSIZE1, 8'h00, 64'h0,
          1, 64'h77,
          1'b0, 1'b0, 32'h8000_0200, MSIZE4, 8'h00, 64'h0};
    applyStimulus(v);
    runTxn(v, 1'b1, "post-reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory port between the fetch-stage instruction bus (ibus) and the memory-stage data bus (dbus).
- Sits between the datapath and the memory subsystem.
- Runs one single-beat transaction at a time, in three stages: grant, issue downstream, return response to the winner.
- Data requests take priority so the memory stage is not stalled by the fetch stage; a starvation guard bounds how long fetch can be held off.

Parameters:
- MAX_DATA_STREAK, 4: consecutive dbus grants allowed while ibus is pending; after that, ibus wins the next arbitration.
- STREAK_W, 3: width of the streak counter; must hold MAX_DATA_STREAK.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ireq  in  ibus_req_t  instruction request (valid, addr).
- iresp  out  ibus_resp_t  instruction response (addr_ok, data_ok, data).
- dreq  in  dbus_req_t  data request (valid, addr, size, strobe, data).
- dresp  out  dbus_resp_t  data response (addr_ok, data_ok, data).
- creq  out  cbus_req_t  downstream request (valid, is_write, size, addr, strobe, data).
- cresp  in  cbus_resp_t  downstream response (ready, data).
- busy  out  1  a transaction is in flight (state != IDLE).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, streak=0, owner=NONE. All outputs 0: creq.valid, iresp/dresp addr_ok and data_ok, data fields, busy.
- States: IDLE, ISSUE, RESP.
- IDLE: if any valid request exists, choose a winner and latch its request into creq_q; next state ISSUE.
  - Only dreq.valid: grant D.
  - Only ireq.valid: grant I.
  - Both valid and streak < MAX_DATA_STREAK: grant D.
  - Both valid and streak == MAX_DATA_STREAK: grant I.
- ISSUE: creq driven from creq_q, valid=1, held stable until cresp.ready.
  - creq.is_write = (owner==D) && (strobe != 0).
  - ibus transactions use size MSIZE4, strobe 0.
  - On cresp.ready: latch cresp.data into rdata_q; next state RESP. creq.valid deasserts in the cycle after ready.
- RESP: for exactly one cycle, assert addr_ok=1 and data_ok=1 (both 1) with data=rdata_q on the owner's response port only. The other port stays all 0. Next state IDLE.
- Latency: request visible in IDLE at cycle 0 → creq.valid at cycle 1 → ready at cycle k≥1 → data_ok at cycle k+1. The fastest case is k=1, giving data_ok at cycle 2.
- Streak counter, updated in IDLE on grant:
  - D granted while ireq.valid=1: streak+1, saturating at MAX_DATA_STREAK.
  - D granted while ireq.valid=0: streak=0.
  - I granted: streak=0.
- Requester rules: a requester holds valid and payload until its data_ok. The arbiter samples the payload only in IDLE, so later payload changes are ignored.
- Requester drops valid mid-transaction: the downstream access still completes; RESP is still entered, but data_ok is suppressed if the owner's valid is 0 in RESP.
- Back-to-back: a request still valid in the RESP cycle is not re-granted; arbitration happens in the following IDLE cycle. Each transaction therefore costs at least 3 cycles.
- Reset mid-transaction: immediate return to IDLE with outputs 0. The downstream access is abandoned; the memory side is reset on the same rst.
- cresp.ready outside ISSUE is ignored.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: when both requesters are valid, grant alternates. The winner is the port that did not win the previous grant; the reset preference is D. The streak counter is not instantiated and MAX_DATA_STREAK is unused.
- Undefined: fixed data priority with the starvation guard, as specified above.

Decomposition:
- Shared package common:
  - cbus_req_t, cbus_resp_t.
  - msize_t (MSIZE1/2/4/8).
  - arb_state_t (IDLE/ISSUE/RESP).
  - arb_owner_t (NONE/I/D).
- Sub-module arb_select: combinational winner pick plus streak-counter register. It isolates the policy so ARB_ROUND_ROBIN_EN swaps only this sub-module.
- The FSM and data path stay in mem_bus_arbiter.

Test Plan:
- Only ireq.valid, addr=0x8000_0000; memory ready one cycle after creq.valid with data 0x00000013 → creq.addr=0x8000_0000, is_write=0; iresp.data_ok pulses exactly once with data 0x13; dresp stays 0.
- Both valid at reset-idle (dreq addr 0x8000_1000, strobe 0xFF, data 0xDEADBEEF) → D granted first with creq.is_write=1; I granted on the next IDLE.
- ireq held valid, dreq re-asserted immediately after each data_ok, MAX_DATA_STREAK=4 → exactly 4 D grants, then 1 I grant; streak observed as 0 after the I grant.
- Memory ready delayed 5 cycles → creq payload constant for all 6 ISSUE cycles; data_ok exactly one cycle after ready.
- rst asserted in the middle of ISSUE → same-cycle creq.valid=0 and busy=0; after release, a fresh ireq completes normally.
- With ARB_ROUND_ROBIN_EN, both requesters continuously valid → grants strictly alternate D, I, D, I.
